// File: rtl/data_memory.sv
// data_memory: byte-wide array with synchronous write and asynchronous read.
// The read register lives in the caller so this body maps onto plain RAM.
module data_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] r_mem [2**ADDR_W] = '{default: 8'h00};

    always_ff @(posedge clock) begin
        if (we) r_mem[addr] <= wdata;
    end

    assign rdata = r_mem[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access, branch resolution and the MEM/WB register.
// Loads are registered here so they share the MEM/WB timing of the other fields.
module mem_wb_stage #(
    parameter int PC_SIZE     = 10,
    parameter int DMEM_ADDR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_SIZE-1:0] PC_jump,
    input  logic               zero,
    input  logic [7:0]         ALU_result,
    input  logic [7:0]         write_data,
    input  logic               branch_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               mem_to_reg_in,
    input  logic               reg_write_in,
    input  logic [4:0]         write_register_in,
    output logic               pc_src,
    output logic [PC_SIZE-1:0] PC_target,
    output logic [7:0]         read_data,
    output logic [7:0]         alu_result_out,
    output logic               mem_to_reg_out,
    output logic               reg_write_out,
    output logic [4:0]         write_register_out,
    output logic [7:0]         wb_write_data
);
    logic [DMEM_ADDR_W-1:0] w_addr;
    logic [7:0]             w_rdata;
    logic                   w_we;
    logic [7:0]             r_read_data;
    logic [7:0]             r_alu_result;
    logic                   r_mem_to_reg;
    logic                   r_reg_write;
    logic [4:0]             r_write_register;

    // Upper address bits drop off, so small memories wrap modulo their depth.
    assign w_addr = DMEM_ADDR_W'(ALU_result);
    assign w_we   = mem_write_in & ~reset;

    data_memory #(.ADDR_W(DMEM_ADDR_W)) u_dmem (
        .clock (clock),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (write_data),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_data      <= 8'h00;
            r_alu_result     <= 8'h00;
            r_mem_to_reg     <= 1'b0;
            r_reg_write      <= 1'b0;
            r_write_register <= 5'd0;
        end else begin
            r_read_data      <= mem_read_in ? w_rdata : 8'h00;
            r_alu_result     <= ALU_result;
            r_mem_to_reg     <= mem_to_reg_in;
            r_reg_write      <= reg_write_in;
            r_write_register <= write_register_in;
        end
    end

    assign pc_src             = branch_in & zero;
    assign PC_target          = PC_jump;
    assign read_data          = r_read_data;
    assign alu_result_out     = r_alu_result;
    assign mem_to_reg_out     = r_mem_to_reg;
    assign reg_write_out      = r_reg_write;
    assign write_register_out = r_write_register;
    assign wb_write_data      = r_mem_to_reg ? r_read_data : r_alu_result;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plan cases plus random traffic against an array-based model.
// A second instance with a 16-byte memory exercises address wrap on the same stimulus.
module tb_mem_wb_stage;
    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] PC_jump;
    logic       zero;
    logic [7:0] ALU_result;
    logic [7:0] write_data;
    logic       branch_in;
    logic       mem_read_in;
    logic       mem_write_in;
    logic       mem_to_reg_in;
    logic       reg_write_in;
    logic [4:0] write_register_in;

    logic       pc_src, pc_src4;
    logic [9:0] PC_target, PC_target4;
    logic [7:0] read_data, read_data4;
    logic [7:0] alu_result_out, alu_result_out4;
    logic       mem_to_reg_out, mem_to_reg_out4;
    logic       reg_write_out, reg_write_out4;
    logic [4:0] write_register_out, write_register_out4;
    logic [7:0] wb_write_data, wb_write_data4;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_mem4 [16];
    logic [7:0] e_rd, e_rd4, e_alu;
    logic       e_m2r, e_rw;
    logic [4:0] e_wr;

    always #5 clock = ~clock;

    mem_wb_stage #(.PC_SIZE(10), .DMEM_ADDR_W(8)) u_dut (
        .clock(clock), .reset(reset), .PC_jump(PC_jump), .zero(zero),
        .ALU_result(ALU_result), .write_data(write_data), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .write_register_in(write_register_in), .pc_src(pc_src), .PC_target(PC_target),
        .read_data(read_data), .alu_result_out(alu_result_out),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .write_register_out(write_register_out), .wb_write_data(wb_write_data)
    );

    mem_wb_stage #(.PC_SIZE(10), .DMEM_ADDR_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .PC_jump(PC_jump), .zero(zero),
        .ALU_result(ALU_result), .write_data(write_data), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .write_register_in(write_register_in), .pc_src(pc_src4), .PC_target(PC_target4),
        .read_data(read_data4), .alu_result_out(alu_result_out4),
        .mem_to_reg_out(mem_to_reg_out4), .reg_write_out(reg_write_out4),
        .write_register_out(write_register_out4), .wb_write_data(wb_write_data4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        #1;
        check("pc_src", pc_src, branch_in & zero);
        check("pc_target", PC_target, PC_jump);
        check("pc_src4", pc_src4, branch_in & zero);
        @(posedge clock);
        if (reset) begin
            {e_rd, e_rd4, e_alu, e_m2r, e_rw, e_wr} = '0;
        end else begin
            e_rd  = mem_read_in ? m_mem[ALU_result] : 8'h00;
            e_rd4 = mem_read_in ? m_mem4[ALU_result % 16] : 8'h00;
            if (mem_write_in) begin
                m_mem[ALU_result]       = write_data;
                m_mem4[ALU_result % 16] = write_data;
            end
            e_alu = ALU_result;
            e_m2r = mem_to_reg_in;
            e_rw  = reg_write_in;
            e_wr  = write_register_in;
        end
        @(negedge clock);
        check("read_data", read_data, e_rd);
        check("alu_out", alu_result_out, e_alu);
        check("m2r_out", mem_to_reg_out, e_m2r);
        check("rw_out", reg_write_out, e_rw);
        check("wr_out", write_register_out, e_wr);
        check("wb_data", wb_write_data, e_m2r ? e_rd : e_alu);
        check("read_data4", read_data4, e_rd4);
        check("wb_data4", wb_write_data4, e_m2r ? e_rd4 : e_alu);
    endtask

    task automatic drive(input logic rst, input logic [7:0] alu, input logic [7:0] wd,
                         input logic rd, input logic wr, input logic m2r);
        reset         = rst;
        ALU_result    = alu;
        write_data    = wd;
        mem_read_in   = rd;
        mem_write_in  = wr;
        mem_to_reg_in = m2r;
        PC_jump           = 10'($urandom);
        zero              = 1'($urandom);
        branch_in         = 1'($urandom);
        reg_write_in      = 1'($urandom);
        write_register_in = 5'($urandom);
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_mem4[i] = 8'h00;
        {e_rd, e_rd4, e_alu, e_m2r, e_rw, e_wr} = '0;
        // Reset with a pending store that must not land
        drive(1'b1, 8'h10, 8'($urandom), 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8'h10, 8'($urandom), 1'b1, 1'b1, 1'b1);
        check("rst_alu", alu_result_out, 0);
        check("rst_rw", reg_write_out, 0);
        check("rst_wb", wb_write_data, 0);
        drive(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        check("rst_nostore", read_data, 8'h00);
        drive(1'b0, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1);
        check("st_ld_rd", read_data, 8'hA5);
        check("st_ld_wb", wb_write_data, 8'hA5);
        drive(1'b0, 8'h20, 8'h11, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h20, 8'h22, 1'b1, 1'b1, 1'b1);
        check("rbw_old", read_data, 8'h11);
        drive(1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 1'b1);
        check("rbw_new", read_data, 8'h22);
        reset = 1'b0; branch_in = 1'b1; zero = 1'b1; PC_jump = 10'h155;
        #1;
        check("br_taken", pc_src, 1);
        check("br_target", PC_target, 10'h155);
        zero = 1'b0;
        #1;
        check("br_nz", pc_src, 0);
        branch_in = 1'b0; zero = 1'b1;
        #1;
        check("br_nobr", pc_src, 0);
        @(negedge clock);
        ALU_result = 8'h7E; mem_to_reg_in = 1'b0; reg_write_in = 1'b1;
        write_register_in = 5'd5; mem_read_in = 1'b0; mem_write_in = 1'b0;
        step();
        check("pass_alu", alu_result_out, 8'h7E);
        check("pass_wb", wb_write_data, 8'h7E);
        check("pass_rw", reg_write_out, 1);
        check("pass_wr", write_register_out, 5);
        check("pass_rd", read_data, 8'h00);
        drive(1'b0, 8'h13, 8'h99, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1);
        check("wrap_rd4", read_data4, 8'h99);
        for (int n = 0; n < 400; n++)
            drive(($urandom_range(0, 19) == 0), 8'($urandom_range(0, 63)), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the EX/MEM register outputs.
- Performs the data-memory access, resolves the branch decision for the fetch stage and holds the MEM/WB pipeline register.
- Also drives the write-back value used by the register file and by the execute stage's forwarding mux.
- Contains the data memory, a synchronous-write / registered-read byte array.

Parameters:
- PC_SIZE, 10, width of program-counter values passed through for the branch target.
- DMEM_ADDR_W, 8, data memory address width; depth = 2^DMEM_ADDR_W bytes.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- PC_jump  in  PC_SIZE  branch target from the EX/MEM register
- zero  in  1  ALU zero flag from EX/MEM
- ALU_result  in  8  ALU result / memory address from EX/MEM
- write_data  in  8  store data from EX/MEM
- branch_in  in  1  branch instruction flag
- mem_read_in  in  1  load flag
- mem_write_in  in  1  store flag
- mem_to_reg_in  in  1  write-back source select
- reg_write_in  in  1  register-write flag
- write_register_in  in  5  destination register
- pc_src  out  1  take-branch to fetch stage (combinational)
- PC_target  out  PC_SIZE  branch target to fetch stage (combinational pass-through of PC_jump)
- read_data  out  8  MEM/WB: loaded byte
- alu_result_out  out  8  MEM/WB: ALU result
- mem_to_reg_out  out  1  MEM/WB: write-back select
- reg_write_out  out  1  MEM/WB: register-write enable
- write_register_out  out  5  MEM/WB: destination register
- wb_write_data  out  8  final write-back value (combinational from MEM/WB)

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: all MEM/WB outputs are 0 on the edge where reset=1. wb_write_data is therefore 0. Memory contents are retained.
- Stores during reset: mem_write_in is ignored while reset=1, so no store occurs.
- Branch decision: pc_src = branch_in & zero, same cycle, no register. PC_target = PC_jump. pc_src is not gated by reset.
- Address: ALU_result[DMEM_ADDR_W-1:0]. Upper bits are ignored when DMEM_ADDR_W<8, giving modulo wrap.
- Store: on a rising edge with mem_write_in=1 and reset=0, mem[addr] <= write_data.
- Load: on a rising edge with reset=0, read_data <= mem_read_in ? mem[addr] : 8'h00. Latency is 1 cycle, aligned with the rest of MEM/WB.
- Simultaneous load and store to the same address in one cycle: the load returns the old contents (read-before-write). The new value is visible to the next cycle's load.
- Back-to-back store at edge N, then load of the same address: the load registered at edge N+1 returns the stored value.
- MEM/WB register: on each non-reset edge, alu_result_out, mem_to_reg_out, reg_write_out and write_register_out capture their inputs unconditionally. There is no stall or flush input.
- Write-back: wb_write_data = mem_to_reg_out ? read_data : alu_result_out.
- Register x0: reg_write_out is not suppressed for write_register=0. The register file ignores writes to x0.
- Memory at time zero: initialised to all zeros in simulation.

Decomposition:
- No shared package is required. Control encodings are single-bit flags.
- One sub-module, data_memory, with parameter ADDR_W and ports clock, we, addr, wdata, rdata.
  - Synchronous write, asynchronous read of the byte array.
  - The read register and the read-enable gating live in mem_wb_stage, so data_memory infers distributed or block RAM cleanly.

Test Plan:
- Reset: reset=1 for 2 cycles with random inputs and mem_write_in=1 at address 0x10 -> all MEM/WB outputs are 0, wb_write_data=0, and a later load of 0x10 returns 0x00.
- Store then load: store 0xA5 at addr 0x3C (mem_write_in=1); next cycle load 0x3C (mem_read_in=1, mem_to_reg_in=1) -> one cycle later read_data=0xA5 and wb_write_data=0xA5.
- Same-cycle conflict: mem[0x20]=0x11; assert mem_read_in and mem_write_in at 0x20 with write_data=0x22 -> read_data=0x11; a following load returns 0x22.
- Branch: branch_in=1, zero=1, PC_jump=0x155 -> pc_src=1 and PC_target=0x155 in the same cycle. With zero=0 -> pc_src=0. With branch_in=0 and zero=1 -> pc_src=0.
- ALU pass-through: ALU_result=0x7E, mem_to_reg_in=0, reg_write_in=1, write_register_in=5 -> next cycle alu_result_out=0x7E, wb_write_data=0x7E, reg_write_out=1, write_register_out=5, read_data=0x00.
- Address wrap: DMEM_ADDR_W=4; store 0x99 at ALU_result=0x13, load at 0x03 -> read_data=0x99.
